bht_sat_table: RTL

//  Parametrised branch history table of N-bit saturating counters, indexed by low PC bits.

---
 rtl/bht_sat_table.sv | 115 +++++++++++
 1 files changed

// File: rtl/bht_sat_table.sv
// Branch history table of saturating counters with built-in read-modify-write update,
// a registered predict port and a post-reset sweep that loads every entry with INIT_CTR.
module bht_sat_table #(
    parameter int IDX_W    = 10,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_addr,
    output logic             pred_out_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_addr,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;
    localparam logic [CTR_W-1:0] INIT_V  = CTR_W'(INIT_CTR);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating step: never wraps at either end.
    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c,
                                                  input logic             taken);
        logic [CTR_W-1:0] r;
        if (taken) begin
            r = (c == CTR_MAX) ? c : c + CTR_W'(1);
        end else begin
            r = (c == CTR_MIN) ? c : c - CTR_W'(1);
        end
        return r;
    endfunction

    state_t           state;
    logic [IDX_W-1:0] sweep_ptr;
    logic [CTR_W-1:0] table_mem [DEPTH];

    logic             pred_fire;
    logic             upd_fire;
    logic             same_idx;
    logic [CTR_W-1:0] upd_old;
    logic [CTR_W-1:0] upd_new;
    logic [CTR_W-1:0] pred_rd;

    logic             pred_vld_p1;
    logic [CTR_W-1:0] pred_ctr_p1;

    always_comb begin
        pred_fire = pred_valid && ready;
        upd_fire  = upd_valid && ready;
        same_idx  = (pred_addr == upd_addr);
        upd_old   = table_mem[upd_addr];
        upd_new   = sat_step(upd_old, upd_taken);
        pred_rd   = table_mem[pred_addr];
        if (BYPASS && upd_fire && same_idx) begin
            pred_rd = upd_new;
        end
    end

    // ---- p0 -> p1: control FSM and registered predict outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_INIT;
            sweep_ptr   <= '0;
            ready       <= 1'b0;
            pred_vld_p1 <= 1'b0;
            pred_ctr_p1 <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (sweep_ptr == '1) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                    ready <= 1'b0;
                end
            endcase
            pred_vld_p1 <= pred_fire;
            if (pred_fire) begin
                pred_ctr_p1 <= pred_rd;
            end
        end
    end

    // Table storage is not reset; the sweep owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            table_mem[sweep_ptr] <= INIT_V;
        end else if (upd_fire) begin
            table_mem[upd_addr] <= upd_new;
        end
    end

    assign pred_out_valid = pred_vld_p1;
    assign pred_ctr       = pred_ctr_p1;
    assign pred_taken     = pred_ctr_p1[CTR_W-1];

endmodule
